// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : cpu_pkg
// Description : Shared constants for the 5-stage MIPS pipeline: datapath
//               width, the NOP encoding (sll $0,$0,0) and the upper bit
//               positions of each MIPS instruction field.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [DATA_W-1:0] NOP = '0;

  // Upper bit of each MIPS field within a 32-bit instruction word
  localparam int unsigned OP_HI = 31;
  localparam int unsigned RS_HI = 25;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RD_HI = 15;
  localparam int unsigned SA_HI = 10;
  localparam int unsigned FN_HI = 5;

  localparam int unsigned OP_W  = 6;
  localparam int unsigned REG_W = 5;
  localparam int unsigned FN_W  = 6;
  localparam int unsigned IMM_W = 16;
  localparam int unsigned TGT_W = 26;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_id_register_if.sv
`default_nettype none
// ============================================================================
// Interface   : if_id_register_if
// Description : Bundle between the IF stage, the IF/ID register and the ID
//               stage.
//               master : fetch/hazard side - drives flush, write enable,
//                        instruction and PC+4; observes the ID outputs.
//               slave  : the IF/ID register itself.
//               Signals:
//                 IF_ID_Flush, IF_ID_Wre          control (1 bit each)
//                 IF_Instruction, IF_PCadd4       fetched word and PC+4
//                 ID_Instruction, ID_PCadd4       registered word and PC+4
//                 Opcode, rs, rt, rd, sa, func,   decoded fields of
//                 Immediate, targetAddress        ID_Instruction
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_register_if;
  import cpu_pkg::*;

  logic                IF_ID_Flush;
  logic                IF_ID_Wre;
  logic [DATA_W-1:0]   IF_Instruction;
  logic [DATA_W-1:0]   IF_PCadd4;

  logic [DATA_W-1:0]   ID_Instruction;
  logic [DATA_W-1:0]   ID_PCadd4;
  logic [OP_W-1:0]     Opcode;
  logic [REG_W-1:0]    rs;
  logic [REG_W-1:0]    rt;
  logic [REG_W-1:0]    rd;
  logic [REG_W-1:0]    sa;
  logic [FN_W-1:0]     func;
  logic [IMM_W-1:0]    Immediate;
  logic [TGT_W-1:0]    targetAddress;

  modport master (
    output IF_ID_Flush, IF_ID_Wre, IF_Instruction, IF_PCadd4,
    input  ID_Instruction, ID_PCadd4, Opcode, rs, rt, rd, sa, func,
           Immediate, targetAddress
  );

  modport slave (
    input  IF_ID_Flush, IF_ID_Wre, IF_Instruction, IF_PCadd4,
    output ID_Instruction, ID_PCadd4, Opcode, rs, rt, rd, sa, func,
           Immediate, targetAddress
  );

endinterface : if_id_register_if
`default_nettype wire

// File: rtl/instr_field_split.sv
`default_nettype none
// ============================================================================
// Module      : instr_field_split
// Description : Purely combinational split of a 32-bit MIPS instruction into
//               its R/I/J-format fields. Shared by IF/ID and the ID stage.
//   instr         in  32  instruction word
//   Opcode        out  6  instr[31:26]
//   rs            out  5  instr[25:21]
//   rt            out  5  instr[20:16]
//   rd            out  5  instr[15:11]
//   sa            out  5  instr[10:6]
//   func          out  6  instr[5:0]
//   Immediate     out 16  instr[15:0], no extension
//   targetAddress out 26  instr[25:0]
// Revision    : 1.0 - initial release
// ============================================================================
module instr_field_split
  import cpu_pkg::*;
(
  input  wire logic [31:0]       instr,
  output logic      [OP_W-1:0]   Opcode,
  output logic      [REG_W-1:0]  rs,
  output logic      [REG_W-1:0]  rt,
  output logic      [REG_W-1:0]  rd,
  output logic      [REG_W-1:0]  sa,
  output logic      [FN_W-1:0]   func,
  output logic      [IMM_W-1:0]  Immediate,
  output logic      [TGT_W-1:0]  targetAddress
);

  assign Opcode        = instr[OP_HI -: OP_W];
  assign rs            = instr[RS_HI -: REG_W];
  assign rt            = instr[RT_HI -: REG_W];
  assign rd            = instr[RD_HI -: REG_W];
  assign sa            = instr[SA_HI -: REG_W];
  assign func          = instr[FN_HI -: FN_W];
  assign Immediate     = instr[RD_HI:0];
  assign targetAddress = instr[RS_HI:0];

endmodule : instr_field_split
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : if_id_register
// Description : IF/ID pipeline register. Captures the fetched instruction and
//               its PC+4 on each rising Clk edge, squashes to NOP on flush,
//               holds on stall, and exposes the decoded instruction fields.
//   Clk    in  1  system clock, rising edge
//   Reset  in  1  synchronous, active-low
//   bus    slave modport of if_id_register_if (control, IF data in,
//          ID data and decoded fields out)
//   Edge priority: Reset low > Flush > Wre > hold.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_register
  import cpu_pkg::*;
#(
  parameter int unsigned       DATA_W_P = DATA_W,
  parameter logic [DATA_W-1:0] NOP_WORD = NOP
)(
  input  wire logic           Clk,
  input  wire logic           Reset,
  if_id_register_if.slave     bus
);

  logic [DATA_W-1:0] r_instruction;
  logic [DATA_W-1:0] r_pcadd4;
  logic [DATA_W-1:0] w_instruction_nxt;
  logic [DATA_W-1:0] w_pcadd4_nxt;

  // Shared priority mux for both flops; reset and flush share the clear value.
  always_comb begin
    w_instruction_nxt = r_instruction;
    w_pcadd4_nxt      = r_pcadd4;
    if (!Reset || bus.IF_ID_Flush) begin
      w_instruction_nxt = NOP_WORD;
      w_pcadd4_nxt      = '0;
    end else if (bus.IF_ID_Wre) begin
      w_instruction_nxt = bus.IF_Instruction;
      w_pcadd4_nxt      = bus.IF_PCadd4;
    end
  end

  always_ff @(posedge Clk) begin
    r_instruction <= w_instruction_nxt;
    r_pcadd4      <= w_pcadd4_nxt;
  end

  assign bus.ID_Instruction = r_instruction;
  assign bus.ID_PCadd4      = r_pcadd4;

  logic [OP_W-1:0]  w_opcode;
  logic [REG_W-1:0] w_rs;
  logic [REG_W-1:0] w_rt;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_sa;
  logic [FN_W-1:0]  w_func;
  logic [IMM_W-1:0] w_imm;
  logic [TGT_W-1:0] w_target;

  // Fields are taken from the register, never from the IF inputs, so they
  // cannot change between edges.
  instr_field_split u_split (
    .instr         (r_instruction[31:0]),
    .Opcode        (w_opcode),
    .rs            (w_rs),
    .rt            (w_rt),
    .rd            (w_rd),
    .sa            (w_sa),
    .func          (w_func),
    .Immediate     (w_imm),
    .targetAddress (w_target)
  );

  assign bus.Opcode        = w_opcode;
  assign bus.rs            = w_rs;
  assign bus.rt            = w_rt;
  assign bus.rd            = w_rd;
  assign bus.sa            = w_sa;
  assign bus.func          = w_func;
  assign bus.Immediate     = w_imm;
  assign bus.targetAddress = w_target;

endmodule : if_id_register
`default_nettype wire

// File: tb/tb_if_id_register.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_register
// Description : Self-checking bench for if_id_register: a table of directed
//               per-edge vectors plus short hand sequences for field decode,
//               between-edge input changes and reset/flush priority.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_register;

  logic Clk;
  logic Reset;

  if_id_register_if bus ();

  if_id_register dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rst_n;
    logic        flush;
    logic        wre;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t vecs[$];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_fields(input string tag, input logic [5:0] op, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sa,
                              input logic [5:0] fn, input logic [15:0] imm, input logic [25:0] tgt);
    check32({tag, ".Opcode"},        32'(bus.Opcode),        32'(op));
    check32({tag, ".rs"},            32'(bus.rs),            32'(rs));
    check32({tag, ".rt"},            32'(bus.rt),            32'(rt));
    check32({tag, ".rd"},            32'(bus.rd),            32'(rd));
    check32({tag, ".sa"},            32'(bus.sa),            32'(sa));
    check32({tag, ".func"},          32'(bus.func),          32'(fn));
    check32({tag, ".Immediate"},     32'(bus.Immediate),     32'(imm));
    check32({tag, ".targetAddress"}, 32'(bus.targetAddress), 32'(tgt));
  endtask

  // Drive away from the active edge, step one rising edge, sample 1 ns later.
  task automatic step(input logic rst_n, input logic flush, input logic wre,
                      input logic [31:0] instr, input logic [31:0] pc4);
    @(negedge Clk);
    Reset              = rst_n;
    bus.IF_ID_Flush    = flush;
    bus.IF_ID_Wre      = wre;
    bus.IF_Instruction = instr;
    bus.IF_PCadd4      = pc4;
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input logic r, input logic f, input logic w, input logic [31:0] i,
                     input logic [31:0] p, input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rst_n = r; v.flush = f; v.wre = w; v.instr = i; v.pc4 = p;
    v.exp_instr = ei; v.exp_pc4 = ep;
    vecs.push_back(v);
  endtask

  initial begin
    Reset              = 1'b0;
    bus.IF_ID_Flush    = 1'b0;
    bus.IF_ID_Wre      = 1'b1;
    bus.IF_Instruction = '0;
    bus.IF_PCadd4      = '0;

    //   rst flush wre  instr          pc4           exp_instr      exp_pc4
    add(0, 0, 1, 32'h8,          32'h4,        32'h0,         32'h0);        // reset
    add(1, 0, 1, 32'h8,          32'h4,        32'h8,         32'h4);        // capture
    add(1, 0, 1, 32'hC,          32'h8,        32'hC,         32'h8);
    add(1, 1, 1, 32'h10,         32'h8,        32'h0,         32'h0);        // flush
    add(1, 0, 1, 32'h14,         32'hC,        32'h14,        32'hC);
    add(1, 0, 0, 32'h18,         32'h10,       32'h14,        32'hC);        // stall
    add(1, 0, 0, 32'h20,         32'h24,       32'h14,        32'hC);        // stall 2nd edge
    add(1, 0, 1, 32'h1C,         32'h14,       32'h1C,        32'h14);       // resume
    add(1, 1, 0, 32'h28,         32'h2C,       32'h0,         32'h0);        // flush over stall
    add(1, 0, 1, 32'hDEADBEEF,   32'h30,       32'hDEADBEEF,  32'h30);
    add(1, 1, 1, 32'h11111111,   32'h34,       32'h0,         32'h0);        // flush x2
    add(1, 1, 0, 32'h22222222,   32'h38,       32'h0,         32'h0);
    add(1, 0, 0, 32'h33333333,   32'h3C,       32'h0,         32'h0);        // stall holds NOP
    add(1, 0, 1, 32'hFFFFFFFF,   32'hFFFFFFFC, 32'hFFFFFFFF,  32'hFFFFFFFC);
    add(0, 1, 1, 32'h55,         32'h66,       32'h0,         32'h0);        // reset beats all
    add(0, 0, 0, 32'h99,         32'h9C,       32'h0,         32'h0);        // reset beats stall hold
    add(1, 0, 1, 32'h77,         32'h88,       32'h77,        32'h88);       // release resumes

    foreach (vecs[k]) begin
      step(vecs[k].rst_n, vecs[k].flush, vecs[k].wre, vecs[k].instr, vecs[k].pc4);
      check32($sformatf("vec%0d.ID_Instruction", k), bus.ID_Instruction, vecs[k].exp_instr);
      check32($sformatf("vec%0d.ID_PCadd4", k),      bus.ID_PCadd4,      vecs[k].exp_pc4);
    end

    // Fields all zero after reset
    step(0, 0, 1, 32'hFFFFFFFF, 32'h4);
    check_fields("reset", 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);

    // lw decode
    step(1, 0, 1, 32'h8CA60010, 32'h40);
    check_fields("lw", 6'h23, 5'd5, 5'd6, 5'd0, 5'd0, 6'h10, 16'h0010, 26'h0A60010);

    // Inputs changing between edges must not reach the outputs
    @(negedge Clk);
    bus.IF_Instruction = 32'h12345678;
    bus.IF_PCadd4      = 32'hABCD;
    bus.IF_ID_Flush    = 1'b1;
    #2;
    check32("glitch.ID_Instruction", bus.ID_Instruction, 32'h8CA60010);
    check32("glitch.ID_PCadd4",      bus.ID_PCadd4,      32'h40);
    check32("glitch.Opcode",         32'(bus.Opcode),    32'h23);

    // add decode
    step(1, 0, 1, 32'h00221820, 32'h44);
    check_fields("add", 6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h1820, 26'h0221820);

    // sa field with a shift instruction: sll $t2,$t1,4 = 0x00095100
    step(1, 0, 1, 32'h00095100, 32'h48);
    check_fields("sll", 6'h0, 5'd0, 5'd9, 5'd10, 5'd4, 6'h00, 16'h5100, 26'h0095100);

    // Fields all zero after flush
    step(1, 1, 1, 32'hFFFFFFFF, 32'h4C);
    check_fields("flush", 6'h0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the stimulus is a few dozen cycles.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule : tb_if_id_register
`default_nettype wire
